// File: rtl/z80_irq_pkg.sv
// z80_irq_pkg: shared types and helpers for the Z80 mode-2 interrupt controller.
package z80_irq_pkg;

    localparam int VEC_STRIDE = 2;

    typedef enum logic [1:0] {SRC_IDLE, SRC_PEND, SRC_INSVC} src_state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } prio_t;

    function automatic prio_t prio_first(input logic [7:0] v);
        prio_t r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                r.found = 1'b1;
                r.idx   = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/z80_irq_ctrl_src_cell.sv
// irq_src_cell: per-source mask, edge/level detect, pending and in-service state.
// IRQ_CTRL_SYNC_EN adds a 2-flop synchroniser on src.
module irq_src_cell #(
    parameter bit EDGE = 1'b1
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic src,
    input  logic mask_we,
    input  logic mask_din,
    input  logic clr,
    input  logic set_insvc,
    input  logic clr_insvc,
    output logic mask_q,
    output logic pend_q,
    output logic isr_q
);
    logic src_s, hist_q, hist_d, mask_d, pend_d, isr_d, trig, mask_eff;

`ifdef IRQ_CTRL_SYNC_EN
    logic [1:0] sync_q, sync_d;
    assign sync_d = {sync_q[0], src};
    assign src_s  = sync_q[1];
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= sync_d;
    end
`else
    assign src_s = src;
`endif

    always_comb begin
        mask_eff = mask_we ? mask_din : mask_q;
        mask_d   = mask_eff;
        hist_d   = src_s;
        trig     = EDGE ? (src_s & ~hist_q & ~mask_eff) : (src_s & ~mask_eff & ~isr_q);
        // a fresh trigger beats software clear and the acknowledge clear
        pend_d   = EDGE ? (trig | (pend_q & ~clr & ~set_insvc & ~mask_eff)) : (trig & ~set_insvc);
        isr_d    = set_insvc | (isr_q & ~clr_insvc);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mask_q <= 1'b1;
            pend_q <= 1'b0;
            isr_q  <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            mask_q <= mask_d;
            pend_q <= pend_d;
            isr_q  <= isr_d;
            hist_q <= hist_d;
        end
    end
endmodule

// File: rtl/z80_irq_ctrl.sv
// z80_irq_ctrl: Z80 mode-2 interrupt controller with priority, vector and IEI/IEO chain.
// Optional macro IRQ_CTRL_SYNC_EN synchronises src inside each source cell.
module z80_irq_ctrl
    import z80_irq_pkg::*;
#(
    parameter int              NSRC      = 4,
    parameter logic [7:0]      VEC_BASE  = 8'h08,
    parameter logic [NSRC-1:0] EDGE_MASK = '1
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_din,
    output logic [NSRC-1:0] mask_q,
    input  logic            clr_we,
    input  logic [NSRC-1:0] clr_sel,
    input  logic            ack,
    input  logic            reti,
    input  logic            iei,
    output logic            ieo,
    output logic            int_n,
    output logic [7:0]      vec_out,
    output logic            vec_oe,
    output logic [NSRC-1:0] pend_q,
    output logic [NSRC-1:0] isr_q
);
    prio_t      isr_f, post_f, win;
    logic [7:0] allow, allow_post, reti_clr, isr_post;
    logic       req, ack_go;
    logic       ack_q, ack_d, int_n_q, int_n_d, vec_oe_q, vec_oe_d;
    logic [7:0] vec_out_q, vec_out_d;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        irq_src_cell #(.EDGE(EDGE_MASK[i])) u_cell (
            .clk_sys   (clk_sys),
            .reset     (reset),
            .src       (src[i]),
            .mask_we   (mask_we),
            .mask_din  (mask_din[i]),
            .clr       (clr_we & clr_sel[i]),
            .set_insvc (ack_go && win.idx == 3'(i)),
            .clr_insvc (reti && isr_f.found && isr_f.idx == 3'(i)),
            .mask_q    (mask_q[i]),
            .pend_q    (pend_q[i]),
            .isr_q     (isr_q[i])
        );
    end

    always_comb begin
        isr_f      = prio_first(8'(isr_q));
        allow      = isr_f.found ? (8'd1 << isr_f.idx) - 8'd1 : 8'hFF;
        req        = iei & |(8'(pend_q) & allow);
        // reti retires its bit before the acknowledge arbitrates
        reti_clr   = (reti && isr_f.found) ? 8'd1 << isr_f.idx : 8'd0;
        isr_post   = 8'(isr_q) & ~reti_clr;
        post_f     = prio_first(isr_post);
        allow_post = post_f.found ? (8'd1 << post_f.idx) - 8'd1 : 8'hFF;
        win        = prio_first(8'(pend_q) & allow_post);
        ack_go     = ack & ~ack_q & iei & win.found;
        ack_d      = ack;
        int_n_d    = ~req;
        vec_oe_d   = ack_go | (ack & vec_oe_q);
        vec_out_d  = ack_go ? VEC_BASE + 8'(VEC_STRIDE) * {5'd0, win.idx} : ack ? vec_out_q : 8'hFF;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ack_q     <= 1'b0;
            int_n_q   <= 1'b1;
            vec_oe_q  <= 1'b0;
            vec_out_q <= 8'hFF;
        end else begin
            ack_q     <= ack_d;
            int_n_q   <= int_n_d;
            vec_oe_q  <= vec_oe_d;
            vec_out_q <= vec_out_d;
        end
    end

    assign int_n   = int_n_q;
    assign vec_oe  = vec_oe_q;
    assign vec_out = vec_out_q;
    assign ieo     = iei & ~|isr_q & ~|(pend_q & ~mask_q);
endmodule

// File: tb/tb_z80_irq_ctrl.sv
// tb_z80_irq_ctrl: directed and randomized checks of z80_irq_ctrl against a behavioural model.
module tb_z80_irq_ctrl;
    localparam logic [3:0] EM = 4'b1110;

    logic       clk_sys = 1'b0, reset = 1'b1;
    logic [3:0] src = '0, mask_din = '0, clr_sel = '0;
    logic       mask_we = 1'b0, clr_we = 1'b0, ack = 1'b0, reti = 1'b0, iei = 1'b1;
    logic [3:0] mask_q, pend_q, isr_q;
    logic       ieo, int_n, vec_oe;
    logic [7:0] vec_out;

    z80_irq_ctrl #(.NSRC(4), .VEC_BASE(8'h08), .EDGE_MASK(EM)) dut (
        .clk_sys (clk_sys), .reset (reset), .src (src),
        .mask_we (mask_we), .mask_din (mask_din), .mask_q (mask_q),
        .clr_we (clr_we), .clr_sel (clr_sel), .ack (ack), .reti (reti),
        .iei (iei), .ieo (ieo), .int_n (int_n), .vec_out (vec_out),
        .vec_oe (vec_oe), .pend_q (pend_q), .isr_q (isr_q)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    logic [3:0] m_mask, m_pend, m_isr, m_hist;
    logic       m_ackp, m_oe, m_intn;
    logic [7:0] m_vec;

    function automatic int first(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 4;
    endfunction

    task automatic model_reset();
        m_mask = 4'hF; m_pend = '0; m_isr = '0; m_hist = '0;
        m_ackp = 0; m_oe = 0; m_intn = 1; m_vec = 8'hFF;
    endtask

    task automatic model_edge();
        logic [3:0] mn, ia, pn;
        int hi, w;
        bit req, go;
        if (reset) begin model_reset(); return; end
        mn  = mask_we ? mask_din : m_mask;
        hi  = first(m_isr);
        w   = first(m_pend);
        req = iei && w < hi;
        ia  = m_isr;
        if (reti && hi < 4) ia[hi] = 1'b0;
        go  = ack && !m_ackp && iei && w < first(ia);
        for (int i = 0; i < 4; i++) begin
            bit taken = go && w == i;
            if (EM[i])
                pn[i] = (src[i] && !m_hist[i] && !mn[i]) ||
                        (m_pend[i] && !(clr_we && clr_sel[i]) && !taken && !mn[i]);
            else
                pn[i] = src[i] && !mn[i] && !m_isr[i] && !taken;
        end
        if (go) begin
            ia[w] = 1'b1; m_oe = 1; m_vec = 8'h08 + 8'(2 * w);
        end else if (!ack) begin
            m_oe = 0; m_vec = 8'hFF;
        end
        m_intn = !req; m_pend = pn; m_isr = ia; m_mask = mn; m_hist = src; m_ackp = ack;
    endtask

    task automatic compare_all();
        check("int_n", int_n, m_intn);
        check("vec_out", vec_out, m_vec);
        check("vec_oe", vec_oe, m_oe);
        check("pend_q", pend_q, m_pend);
        check("isr_q", isr_q, m_isr);
        check("mask_q", mask_q, m_mask);
        check("ieo", ieo, iei && m_isr == 0 && (m_pend & ~m_mask) == 0);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            model_edge();
            @(negedge clk_sys);
            compare_all();
            mask_we = 0; clr_we = 0; reti = 0;
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk_sys);
        check("rst_int_n", int_n, 1'b1);
        check("rst_vec_out", vec_out, 8'hFF);
        check("rst_vec_oe", vec_oe, 1'b0);
        check("rst_mask", mask_q, 4'hF);
        check("rst_pend", pend_q, 4'h0);
        check("rst_isr", isr_q, 4'h0);
        reset = 0;

        mask_din = 4'b0111; mask_we = 1; step();
        src[3] = 1; step();
        check("t1_pend", pend_q, 4'b1000);
        check("t1_int_wait", int_n, 1'b1);
        src[3] = 0; step();
        check("t1_int_low", int_n, 1'b0);
        ack = 1; step();
        check("t1_vec", vec_out, 8'h0E);
        check("t1_oe", vec_oe, 1'b1);
        check("t1_isr", isr_q, 4'b1000);
        step();
        check("t1_int_hi", int_n, 1'b1);
        check("t1_vec_hold", vec_out, 8'h0E);
        ack = 0; step();
        check("t1_oe_drop", vec_oe, 1'b0);
        check("t1_vec_ff", vec_out, 8'hFF);

        mask_din = 4'b0000; mask_we = 1; step();
        src[1] = 1; step();
        src[1] = 0; step();
        check("t2_nest_int", int_n, 1'b0);
        ack = 1; step();
        check("t2_vec", vec_out, 8'h0A);
        check("t2_isr", isr_q, 4'b1010);
        ack = 0; step();
        reti = 1; step();
        check("t2_reti1", isr_q, 4'b1000);
        reti = 1; step();
        check("t2_reti2", isr_q, 4'b0000);

        mask_din = 4'b1111; mask_we = 1; step();
        src[2] = 1; step(2);
        check("t3_masked_pend", pend_q, 4'b0000);
        check("t3_masked_int", int_n, 1'b1);
        mask_din = 4'b0000; mask_we = 1; step(2);
        check("t3_lost_pend", pend_q, 4'b0000);
        check("t3_lost_int", int_n, 1'b1);
        src[2] = 0; step();

        src[0] = 1; step(2);
        check("t4_int", int_n, 1'b0);
        ack = 1; step();
        check("t4_vec", vec_out, 8'h08);
        ack = 0; step();
        check("t4_pend_insvc", pend_q, 4'b0000);
        reti = 1; step(); step();
        check("t4_repend", pend_q[0], 1'b1);
        step();
        check("t4_int_again", int_n, 1'b0);
        src[0] = 0; step(3);

        iei = 0; src[2] = 1; step();
        src[2] = 0; step();
        check("t5_pend", pend_q, 4'b0100);
        check("t5_int", int_n, 1'b1);
        check("t5_ieo", ieo, 1'b0);
        ack = 1; step();
        check("t5_oe", vec_oe, 1'b0);
        ack = 0; step();
        iei = 1; step();
        check("t5_int_low", int_n, 1'b0);
        ack = 1; step();
        ack = 0; step();
        reti = 1; step();

        src[2] = 1; clr_we = 1; clr_sel = 4'b0100; step();
        check("t6_clr_vs_trig", pend_q[2], 1'b1);
        src[2] = 0; step();
        ack = 1; step();
        check("t6_oe", vec_oe, 1'b1);
        #2 reset = 1;
        #1;
        check("t6_rst_oe", vec_oe, 1'b0);
        check("t6_rst_int", int_n, 1'b1);
        check("t6_rst_mask", mask_q, 4'hF);
        model_reset();
        ack = 0; step();
        reset = 0;

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(3) == 0) src[i] = ~src[i];
            mask_we  = ($urandom_range(15) == 0);
            mask_din = 4'($urandom & $urandom);
            clr_we   = ($urandom_range(7) == 0);
            clr_sel  = 4'($urandom);
            reti     = ($urandom_range(9) == 0);
            iei      = ($urandom_range(15) != 0);
            ack      = ack ? ($urandom_range(2) != 0) : ($urandom_range(5) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/z80_irq_ctrl.md
Name: z80_irq_ctrl

Overview:
- Parametrised Z80 mode-2 interrupt controller for the machine cores.
- Replaces the per-core ad-hoc interrupt plumbing: keyboard latch, fixed-vector mux and hand-wired priority.
- Gathers NSRC interrupt sources, each with its own mask, edge or level detect, pending and in-service state, and a priority encoder.
- Drives the vector during the acknowledge cycle and chains into Z80 peripherals (CTC, PIO) through IEI/IEO.

Parameters:
- NSRC, 4: number of interrupt sources (1..8); index 0 is the highest priority.
- VEC_BASE, 8'h08: vector of source 0; source i gets VEC_BASE + 2*i, modulo 256.
- EDGE_MASK, 4'b1111 (NSRC bits): per source, 1 = rising-edge triggered, 0 = level triggered.

Ports:
- clk_sys  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high.
- src  in  NSRC  raw interrupt request lines, active-high.
- mask_we  in  1  one-cycle strobe; loads the mask register from mask_din.
- mask_din  in  NSRC  new mask; 1 = masked.
- mask_q  out  NSRC  mask register readback.
- clr_we  in  1  one-cycle strobe; clears pending bits selected by clr_sel.
- clr_sel  in  NSRC  pending-clear select, one bit per source.
- ack  in  1  interrupt acknowledge level (~m1_n & ~iorq_n, decoded by the parent).
- reti  in  1  one-cycle pulse from the RETI decoder.
- iei  in  1  daisy-chain enable input.
- ieo  out  1  daisy-chain enable output.
- int_n  out  1  interrupt request to the CPU, active-low, registered.
- vec_out  out  8  vector byte.
- vec_oe  out  1  vec_out valid; the parent muxes vec_out onto cpu_din while this is high.
- pend_q  out  NSRC  pending register readback.
- isr_q  out  NSRC  in-service register readback.

Behaviour:
- Reset values:
  - mask = all 1; pending = 0; in-service = 0.
  - int_n = 1; vec_out = 8'hFF; vec_oe = 0; edge history = 0.
  - ieo = iei (combinational).
- Source state per bit: IDLE -> PENDING -> IN_SERVICE -> IDLE.
- Edge sources:
  - PENDING is set on the clk_sys edge where the sample is 1 and the previous sample was 0, with the mask bit 0.
  - Masked edges are discarded, not remembered.
- Level sources:
  - pending = src & ~mask while the source is not in service.
  - A level still high at RETI re-pends on the next cycle.
- Masking:
  - Writing 1 to a mask bit clears that source's pending bit in the same edge.
  - In-service bits are not affected by masking.
- Software clear: clr_we clears pending where clr_sel = 1. A new trigger on the same edge wins, and the bit stays pending.
- Request:
  - req = iei & (some pending source has higher priority than every in-service source).
  - int_n <= ~req on each edge. Latency: src edge sampled at edge k -> pending after edge k -> int_n low after edge k+1.
- Acknowledge, on the first edge where ack is 1 and the previous ack was 0, with req true:
  - winner = lowest-index eligible pending source.
  - Clear the winner's pending bit and set its in-service bit.
  - vec_out <= VEC_BASE + 2*winner; vec_oe <= 1.
- During the acknowledge:
  - vec_oe stays 1 while ack stays high.
  - vec_out is frozen; triggers arriving during ack only update pending.
  - When ack falls: vec_oe <= 0; vec_out <= 8'hFF.
  - An ack rise with req false does nothing: vec_oe stays 0, so a downstream chain device answers.
- Nesting:
  - A higher-priority source may request while a lower one is in service.
  - Equal or lower priority sources are blocked until RETI.
- RETI: clears the highest-priority (lowest-index) in-service bit. Ignored if none is set.
- Daisy chain: ieo = iei & ~|in_service & ~|(pending & ~mask).
- Simultaneous events:
  - Ack and reti on the same edge: reti is applied first, then the winner is computed from the pre-edge pending bits.
  - Mask write and trigger on the same edge: the new mask decides.
- Reset mid-acknowledge: vec_oe drops immediately (asynchronous) and all state clears.

Optional Feature:
- Macro: IRQ_CTRL_SYNC_EN.
- Defined: src passes through a 2-flop synchroniser before edge/level detect; int_n latency grows by 2 cycles (low after edge k+3).
- Undefined: src is sampled directly; the parent guarantees src is synchronous to clk_sys.

Decomposition:
- Package z80_irq_pkg:
  - localparam VEC_STRIDE = 2.
  - Source state enum {SRC_IDLE, SRC_PEND, SRC_INSVC}, used for bench/debug decoding only.
  - Function prio_first(vector) returning the lowest set index plus a found flag.
- Sub-module irq_src_cell: one per source, generated NSRC times. It holds sync/edge detect, pending and in-service flops, and mask gating. The top-level keeps the priority encoder, the ack/vector logic and the daisy chain.

Test Plan:
- Source 3 (edge), mask=4'b0111, pulse src[3] -> int_n low 2 cycles later; ack -> vec_out=8'h0E, vec_oe=1, isr_q=4'b1000, int_n=1.
- Source 3 in service, src[1] edge -> int_n low; ack -> vec_out=8'h0A; reti -> isr_q=4'b1000; second reti -> isr_q=0.
- mask=4'b1111, edge on src[2] -> pend_q stays 0, int_n stays 1. Then mask=0 -> still no request (edge lost).
- Source 0 level (EDGE_MASK=4'b1110), src[0] held high -> ack gives 8'h08; reti while high -> pend_q[0]=1 next cycle, int_n low again.
- iei=0 with src[2] pending -> int_n=1, ieo=0; ack -> vec_oe=0. Then iei=1 -> int_n low after 1 cycle.
- clr_we with clr_sel=4'b0100 and an src[2] edge on the same cycle -> pend_q[2]=1. Assert reset during ack -> vec_oe=0, int_n=1, mask_q=4'b1111.
